// File: rtl/fft_stage_counter_pkg.sv
// Shared FFT index/stage definitions used by the stage counter and its modulo adder.
package fft_stage_counter_pkg;

  localparam int FFT_IDX_W   = 5;
  localparam int FFT_STAGE_W = 3;
  localparam int INIT_ONE    = 1;

endpackage : fft_stage_counter_pkg

// File: rtl/fft_stage_counter_mod_adder.sv
// Combinational modulo adder: (a + b) mod limit_eff, where m==0 selects 2**WIDTH.
module fft_mod_adder
  import fft_stage_counter_pkg::*;
#(
  parameter int WIDTH = FFT_IDX_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] sum_mod,
  output logic             wrapped
);

  logic [WIDTH:0] limit_eff;
  logic [WIDTH:0] sum_ext;
  logic [WIDTH:0] diff_ext;

  // One extra bit so the 2**WIDTH modulus and the carry of a+b are both representable.
  always_comb begin
    limit_eff = (m == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, m};
    sum_ext   = {1'b0, a} + {1'b0, b};
    diff_ext  = sum_ext - limit_eff;
    wrapped   = (sum_ext >= limit_eff);
    sum_mod   = wrapped ? diff_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];
  end

endmodule : fft_mod_adder

// File: rtl/fft_stage_counter.sv
// Modulo index counter with stage tracking and a sticky done flag for FFT address generation.
module fft_stage_counter
  import fft_stage_counter_pkg::*;
#(
  parameter int               WIDTH   = FFT_IDX_W,
  parameter int               STAGE_W = FFT_STAGE_W,
  parameter logic [WIDTH-1:0] INIT    = WIDTH'(INIT_ONE)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   step,
  input  logic [WIDTH-1:0]   limit,
  input  logic [STAGE_W-1:0] num_stages,
  output logic [WIDTH-1:0]   count,
  output logic [STAGE_W-1:0] stage,
  output logic               wrap,
  output logic               done
);

  logic [WIDTH-1:0]   count_p1;
  logic [STAGE_W-1:0] stage_p1;
  logic               wrap_p1;
  logic               done_p1;

  logic [WIDTH-1:0]   sum_mod;
  logic               wrapped;
  logic               last_stage;

  fft_mod_adder #(
    .WIDTH (WIDTH)
  ) u_mod_adder (
    .a       (count_p1),
    .b       (step),
    .m       (limit),
    .sum_mod (sum_mod),
    .wrapped (wrapped)
  );

  // num_stages==0 means free-running, so no stage is ever the last one.
  assign last_stage = (num_stages != '0) &&
                      (stage_p1 == (num_stages - STAGE_W'(1)));

  // Stage p1: all state registered; priority clr > load > en.
  always_ff @(posedge clk) begin
    if (clr) begin
      count_p1 <= INIT;
      stage_p1 <= '0;
      wrap_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else if (load) begin
      count_p1 <= load_val;
      stage_p1 <= '0;
      wrap_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else if (en && !done_p1) begin
      count_p1 <= sum_mod;
      wrap_p1  <= wrapped;
      if (wrapped) begin
        if (last_stage) begin
          done_p1 <= 1'b1;
        end else begin
          stage_p1 <= stage_p1 + STAGE_W'(1);
        end
      end
    end else begin
      wrap_p1 <= 1'b0;
    end
  end

  assign count = count_p1;
  assign stage = stage_p1;
  assign wrap  = wrap_p1;
  assign done  = done_p1;

endmodule : fft_stage_counter

// File: tb/tb_fft_stage_counter.sv
// Directed bench for fft_stage_counter with hand-computed expected values.
module tb_fft_stage_counter;

  localparam int WIDTH   = 5;
  localparam int STAGE_W = 3;

  logic               clk = 1'b0;
  logic               clr = 1'b0;
  logic               en = 1'b0;
  logic               load = 1'b0;
  logic [WIDTH-1:0]   load_val = '0;
  logic [WIDTH-1:0]   step = '0;
  logic [WIDTH-1:0]   limit = '0;
  logic [STAGE_W-1:0] num_stages = '0;
  logic [WIDTH-1:0]   count;
  logic [STAGE_W-1:0] stage;
  logic               wrap;
  logic               done;

  int passed = 0;
  int total  = 0;

  fft_stage_counter #(
    .WIDTH   (WIDTH),
    .STAGE_W (STAGE_W),
    .INIT    (5'd1)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .step       (step),
    .limit      (limit),
    .num_stages (num_stages),
    .count      (count),
    .stage      (stage),
    .wrap       (wrap),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Illegal stimulus guard: step above the modulus, or a load value outside it.
  always @(posedge clk) begin
    int lim;
    lim = (limit == '0) ? 32 : int'(limit);
    if (!clr && load) assert (int'(load_val) < lim) else $error("illegal load_val %0d", load_val);
    if (!clr && !load && en) assert (int'(step) <= lim) else $error("illegal step %0d", step);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input int c, input int s, input int w, input int d);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".stage"}, int'(stage), s);
    chk({tag, ".wrap"},  int'(wrap),  w);
    chk({tag, ".done"},  int'(done),  d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_c2 [8] = '{3, 6, 1, 4, 7, 2, 5, 0};
    int exp_w2 [8] = '{0, 0, 1, 0, 0, 1, 0, 1};
    int exp_s2 [8] = '{0, 0, 1, 1, 1, 2, 2, 3};
    int exp_c3 [4] = '{16, 0, 16, 0};
    int exp_s3 [4] = '{0, 1, 1, 1};
    int exp_w3 [4] = '{0, 1, 0, 1};
    int exp_d3 [4] = '{0, 0, 0, 1};

    // 1 Reset and hold
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("reset_hold", 1, 0, 0, 0);
    end

    // 2 Modulo wrap, limit 8, step 3, free-running stages
    limit = 5'd8; step = 5'd3; num_stages = 3'd0;
    load = 1'b1; load_val = 5'd0;
    tick();
    chk_all("mod_load", 0, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("mod_step%0d", i), exp_c2[i], exp_s2[i], exp_w2[i], 0);
    end

    // 3 Full range modulus and done
    en = 1'b0; limit = 5'd0; step = 5'd16; num_stages = 3'd2;
    load = 1'b1; load_val = 5'd0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("full_step%0d", i), exp_c3[i], exp_s3[i], exp_w3[i], exp_d3[i]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("done_frozen", 0, 1, 0, 1);
    end

    // 4 Priority: load beats en and clears done; clr beats load
    load = 1'b1; en = 1'b1; load_val = 5'd9;
    tick();
    chk_all("load_over_en", 9, 0, 0, 0);
    clr = 1'b1;
    tick();
    chk_all("clr_over_load", 1, 0, 0, 0);
    clr = 1'b0; load = 1'b0; en = 1'b0;

    // 5 Reset on the cycle a wrap would occur
    limit = 5'd8; step = 5'd1; num_stages = 3'd0;
    load = 1'b1; load_val = 5'd7;
    tick();
    chk_all("pre_wrap", 7, 0, 0, 0);
    load = 1'b0; en = 1'b1; clr = 1'b1;
    tick();
    chk_all("midrun_clr", 1, 0, 0, 0);
    clr = 1'b0; en = 1'b0;

    // 6a Zero step holds count, never wraps
    load = 1'b1; load_val = 5'd5; step = 5'd0;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("step_zero", 5, 0, 0, 0);
    end

    // 6b step == limit wraps every cycle, stage counts round modulo 8
    en = 1'b0; limit = 5'd4; step = 5'd4;
    load = 1'b1; load_val = 5'd2;
    tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("step_eq_lim%0d", i), 2, (i + 1) % 8, 1, 0);
    end
    en = 1'b0;
    tick();
    chk_all("en_low_hold", 2, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_fft_stage_counter
